// File: rtl/sgm_pkg.sv
// Shared SGM constants and the median post-filter state encoding.
// Used by the SGM cores, the median filter and their benches.
package sgm_pkg;

  localparam int DISP_WIDTH   = 6;
  localparam int FRAME_WIDTH  = 272;
  localparam int FRAME_HEIGHT = 240;

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } med_state_e;

endpackage

// File: rtl/median9_sorter.sv
// Combinational 9-input median: picks the value whose rank
// window (count below, count below-or-equal) covers position 5.
module median9_sorter #(
  parameter int DISP_WIDTH = sgm_pkg::DISP_WIDTH
) (
  input  logic [8:0][DISP_WIDTH-1:0] win,
  output logic [DISP_WIDTH-1:0]      median
);

  int  lt;
  int  le;
  logic found;

  always_comb begin
    median = win[0];
    found  = 1'b0;
    lt     = 0;
    le     = 0;
    for (int i = 0; i < 9; i++) begin
      lt = 0;
      le = 0;
      for (int j = 0; j < 9; j++) begin
        if (win[j] < win[i])  lt = lt + 1;
        if (win[j] <= win[i]) le = le + 1;
      end
      if (!found && lt <= 4 && le >= 5) begin
        median = win[i];
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/disparity_median3x3.sv
// Streaming 3x3 median post-filter for the SGM disparity raster.
// Border centres pass through; a FLUSH phase drains the last W+1.
module disparity_median3x3 #(
  parameter int FRAME_WIDTH  = sgm_pkg::FRAME_WIDTH,
  parameter int FRAME_HEIGHT = sgm_pkg::FRAME_HEIGHT,
  parameter int DISP_WIDTH   = sgm_pkg::DISP_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DISP_WIDTH-1:0] disparity_in,
  input  logic                  valid_in,
  output logic                  in_ready,
  output logic [DISP_WIDTH-1:0] disparity_out,
  output logic                  valid_out,
  output logic                  frame_done
);
  import sgm_pkg::*;

  localparam int CW = $clog2(FRAME_WIDTH);
  localparam int RW = $clog2(FRAME_HEIGHT + 2);

  typedef logic [DISP_WIDTH-1:0] disp_t;

  med_state_e state_q, state_d;

  logic [CW-1:0] in_col_q, in_col_d;
  logic [RW-1:0] in_row_q, in_row_d;
  logic [CW-1:0] out_col_q, out_col_d;
  logic [RW-1:0] out_row_q, out_row_d;

  disp_t lb0_q [FRAME_WIDTH];
  disp_t lb1_q [FRAME_WIDTH];

  logic [8:0][DISP_WIDTH-1:0] win_q, win_d;

  disp_t dout_q, dout_d;
  logic  vout_q, vout_d;
  logic  fdone_q, fdone_d;

  logic  step, emit;
  logic  fill_done, last_in, last_out, border;
  disp_t lb0_rd, lb1_rd, in_px, centre, median;

  assign lb0_rd = lb0_q[in_col_q];
  assign lb1_rd = lb1_q[in_col_q];
  assign in_px  = (state_q == ST_FLUSH) ? '0 : disparity_in;

  assign fill_done = (in_row_q == RW'(1)) && (in_col_q == '0);
  assign last_in   = (in_row_q == RW'(FRAME_HEIGHT - 1)) &&
                     (in_col_q == CW'(FRAME_WIDTH - 1));
  assign last_out  = (out_row_q == RW'(FRAME_HEIGHT - 1)) &&
                     (out_col_q == CW'(FRAME_WIDTH - 1));
  assign border    = (out_row_q == '0) ||
                     (out_row_q == RW'(FRAME_HEIGHT - 1)) ||
                     (out_col_q == '0) ||
                     (out_col_q == CW'(FRAME_WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_FILL;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_FILL:  if (step && fill_done) state_d = ST_RUN;
      ST_RUN:   if (step && last_in)   state_d = ST_FLUSH;
      ST_FLUSH: if (last_out)          state_d = ST_FILL;
      default:                         state_d = ST_FILL;
    endcase
  end

  always_comb begin
    in_ready = 1'b1;
    step     = 1'b0;
    emit     = 1'b0;
    unique case (state_q)
      ST_FILL:  step = valid_in;
      ST_RUN: begin
        step = valid_in;
        emit = valid_in;
      end
      ST_FLUSH: begin
        in_ready = 1'b0;
        step     = 1'b1;
        emit     = 1'b1;
      end
      default: in_ready = 1'b1;
    endcase
  end

  always_comb begin
    in_col_d  = in_col_q;
    in_row_d  = in_row_q;
    out_col_d = out_col_q;
    out_row_d = out_row_q;
    if (step) begin
      if (in_col_q == CW'(FRAME_WIDTH - 1)) begin
        in_col_d = '0;
        in_row_d = in_row_q + RW'(1);
      end else begin
        in_col_d = in_col_q + CW'(1);
      end
    end
    if (emit) begin
      if (out_col_q == CW'(FRAME_WIDTH - 1)) begin
        out_col_d = '0;
        out_row_d = out_row_q + RW'(1);
      end else begin
        out_col_d = out_col_q + CW'(1);
      end
    end
    if (state_q == ST_FLUSH && last_out) begin
      in_col_d  = '0;
      in_row_d  = '0;
      out_col_d = '0;
      out_row_d = '0;
    end
  end

  // Newest column enters on the right: two rows up, one up, incoming.
  always_comb begin
    win_d = win_q;
    if (step) begin
      for (int r = 0; r < 3; r++) begin
        win_d[r*3 + 0] = win_q[r*3 + 1];
        win_d[r*3 + 1] = win_q[r*3 + 2];
      end
      win_d[2] = lb1_rd;
      win_d[5] = lb0_rd;
      win_d[8] = in_px;
    end
  end

  assign centre = win_d[4];

  median9_sorter #(
    .DISP_WIDTH(DISP_WIDTH)
  ) u_sorter (
    .win    (win_d),
    .median (median)
  );

  always_comb begin
    vout_d  = emit;
    fdone_d = emit && last_out;
    dout_d  = dout_q;
    if (emit) dout_d = border ? centre : median;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_col_q  <= '0;
      in_row_q  <= '0;
      out_col_q <= '0;
      out_row_q <= '0;
      win_q     <= '0;
      dout_q    <= '0;
      vout_q    <= 1'b0;
      fdone_q   <= 1'b0;
    end else begin
      in_col_q  <= in_col_d;
      in_row_q  <= in_row_d;
      out_col_q <= out_col_d;
      out_row_q <= out_row_d;
      win_q     <= win_d;
      dout_q    <= dout_d;
      vout_q    <= vout_d;
      fdone_q   <= fdone_d;
    end
  end

  always_ff @(posedge clk) begin
    if (step) begin
      lb1_q[in_col_q] <= lb0_rd;
      lb0_q[in_col_q] <= in_px;
    end
  end

  assign disparity_out = dout_q;
  assign valid_out     = vout_q;
  assign frame_done    = fdone_q;

endmodule

// File: tb/tb_disparity_median3x3.sv
// Bench for disparity_median3x3 on a reduced frame with a
// sort-based golden median model.
module tb_disparity_median3x3;

  localparam int W  = 10;
  localparam int H  = 7;
  localparam int DW = 6;
  localparam int WH = W * H;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DW-1:0] disparity_in = '0;
  logic          valid_in = 1'b0;
  logic          in_ready;
  logic [DW-1:0] disparity_out;
  logic          valid_out;
  logic          frame_done;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] frm  [WH];
  logic [DW-1:0] exp_v[WH];
  logic [DW-1:0] exp_a[WH];

  logic [DW-1:0] out_q[$];
  int            fd_q[$];
  int            stray_fd = 0;
  int            rdy_low  = 0;

  disparity_median3x3 #(
    .FRAME_WIDTH (W),
    .FRAME_HEIGHT(H),
    .DISP_WIDTH  (DW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .disparity_in (disparity_in),
    .valid_in     (valid_in),
    .in_ready     (in_ready),
    .disparity_out(disparity_out),
    .valid_out    (valid_out),
    .frame_done   (frame_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (valid_out) begin
      out_q.push_back(disparity_out);
      if (frame_done) fd_q.push_back(out_q.size() - 1);
    end else if (frame_done) begin
      stray_fd++;
    end
    if (!in_ready) rdy_low++;
  end

  function automatic void build_golden();
    int v[9];
    int t;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        if (r == 0 || r == H-1 || c == 0 || c == W-1) begin
          exp_v[r*W + c] = frm[r*W + c];
        end else begin
          for (int dr = 0; dr < 3; dr++)
            for (int dc = 0; dc < 3; dc++)
              v[dr*3 + dc] = int'(frm[(r+dr-1)*W + (c+dc-1)]);
          for (int i = 1; i < 9; i++)
            for (int j = i; j > 0 && v[j-1] > v[j]; j--) begin
              t = v[j]; v[j] = v[j-1]; v[j-1] = t;
            end
          exp_v[r*W + c] = DW'(v[4]);
        end
      end
    end
  endfunction

  task automatic clear_mon();
    out_q.delete();
    fd_q.delete();
    stray_fd = 0;
    rdy_low  = 0;
  endtask

  task automatic send_frame(input bit gaps, input int n_px);
    int  i = 0;
    int  guard = 0;
    bit  acc;
    while (i < n_px && guard < 20 * WH) begin
      @(negedge clk);
      valid_in     = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      disparity_in = valid_in ? frm[i] : DW'($urandom);
      acc = valid_in && in_ready;
      @(posedge clk);
      if (acc) i++;
      guard++;
    end
    if (i < n_px) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout accepted=%0d required=%0d", i, n_px);
    end
  endtask

  task automatic drain(input int n_out);
    int cyc = 0;
    @(negedge clk);
    valid_in = 1'b0;
    while (out_q.size() < n_out && cyc < 8 * WH) begin
      @(negedge clk);
      cyc++;
    end
    repeat (2 * W) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    valid_in = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks += 4;
    if (valid_out !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid got=%b want=0", valid_out);
    end
    if (disparity_out !== '0) begin
      n_fail++; $display("FAIL reset_data got=%0d want=0", disparity_out);
    end
    if (frame_done !== 1'b0) begin
      n_fail++; $display("FAIL reset_fdone got=%b want=0", frame_done);
    end
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready got=%b want=1", in_ready);
    end
  endtask

  task automatic test_constant();
    int bad = 0;
    for (int i = 0; i < WH; i++) frm[i] = DW'(7);
    clear_mon();
    send_frame(1'b0, WH);
    drain(WH);
    n_checks += 5;
    if (out_q.size() != WH) begin
      n_fail++; $display("FAIL const_count got=%0d want=%0d", out_q.size(), WH);
    end
    for (int i = 0; i < out_q.size(); i++) if (out_q[i] !== DW'(7)) bad++;
    if (bad != 0) begin
      n_fail++; $display("FAIL const_values bad=%0d want=0", bad);
    end
    if (fd_q.size() != 1) begin
      n_fail++; $display("FAIL const_fdone_cnt got=%0d want=1", fd_q.size());
    end else if (fd_q[0] != WH - 1) begin
      n_fail++; $display("FAIL const_fdone_pos got=%0d want=%0d", fd_q[0], WH-1);
    end
    if (stray_fd != 0) begin
      n_fail++; $display("FAIL const_stray_fdone got=%0d want=0", stray_fd);
    end
    if (rdy_low != W + 1) begin
      n_fail++; $display("FAIL const_ready_low got=%0d want=%0d", rdy_low, W+1);
    end
  endtask

  task automatic test_salt();
    int bad = 0;
    for (int i = 0; i < WH; i++) frm[i] = '0;
    frm[3*W + 3] = DW'(63);
    clear_mon();
    send_frame(1'b0, WH);
    drain(WH);
    n_checks += 3;
    if (out_q.size() != WH) begin
      n_fail++; $display("FAIL salt_count got=%0d want=%0d", out_q.size(), WH);
    end
    if (out_q.size() == WH && out_q[3*W + 3] !== '0) begin
      n_fail++; $display("FAIL salt_centre got=%0d want=0", out_q[3*W+3]);
    end
    for (int i = 0; i < out_q.size(); i++) if (out_q[i] !== '0) bad++;
    if (bad != 0) begin
      n_fail++; $display("FAIL salt_others bad=%0d want=0", bad);
    end
  endtask

  task automatic test_border();
    int pos[4];
    pos[0] = 0*W + 5;
    pos[1] = 5*W + 0;
    pos[2] = (H-1)*W + 5;
    pos[3] = 5*W + (W-1);
    for (int i = 0; i < WH; i++) frm[i] = '0;
    for (int k = 0; k < 4; k++) frm[pos[k]] = DW'(63);
    clear_mon();
    send_frame(1'b0, WH);
    drain(WH);
    n_checks++;
    if (out_q.size() != WH) begin
      n_fail++; $display("FAIL border_count got=%0d want=%0d", out_q.size(), WH);
    end
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (out_q.size() != WH || out_q[pos[k]] !== DW'(63)) begin
        n_fail++;
        $display("FAIL border_pt%0d got=%0d want=63", k,
                 out_q.size() == WH ? out_q[pos[k]] : 0);
      end
    end
  endtask

  task automatic test_random(input bit gaps);
    int bad = 0;
    for (int i = 0; i < WH; i++) frm[i] = DW'($urandom_range(0, 63));
    build_golden();
    clear_mon();
    send_frame(gaps, WH);
    drain(WH);
    n_checks += 2;
    if (out_q.size() != WH) begin
      n_fail++;
      $display("FAIL rand%0d_count got=%0d want=%0d", gaps, out_q.size(), WH);
    end
    for (int i = 0; i < out_q.size() && i < WH; i++)
      if (out_q[i] !== exp_v[i]) begin
        if (bad < 4)
          $display("FAIL rand%0d_px%0d got=%0d want=%0d",
                   gaps, i, out_q[i], exp_v[i]);
        bad++;
      end
    if (bad != 0) n_fail++;
  endtask

  task automatic test_back_to_back();
    int bad = 0;
    for (int i = 0; i < WH; i++) frm[i] = DW'($urandom_range(0, 63));
    build_golden();
    exp_a = exp_v;
    clear_mon();
    send_frame(1'b0, WH);
    for (int i = 0; i < WH; i++) frm[i] = DW'($urandom_range(0, 63));
    build_golden();
    send_frame(1'b0, WH);
    drain(2 * WH);
    n_checks += 4;
    if (out_q.size() != 2 * WH) begin
      n_fail++; $display("FAIL b2b_count got=%0d want=%0d", out_q.size(), 2*WH);
    end
    if (fd_q.size() != 2) begin
      n_fail++; $display("FAIL b2b_fdone got=%0d want=2", fd_q.size());
    end
    for (int i = 0; i < WH && i < out_q.size(); i++)
      if (out_q[i] !== exp_a[i]) bad++;
    if (bad != 0) begin
      n_fail++; $display("FAIL b2b_frame1 bad=%0d want=0", bad);
    end
    bad = 0;
    for (int i = 0; i < WH && WH + i < out_q.size(); i++)
      if (out_q[WH + i] !== exp_v[i]) bad++;
    if (bad != 0) begin
      n_fail++; $display("FAIL b2b_frame2 bad=%0d want=0", bad);
    end
  endtask

  task automatic test_mid_reset();
    int bad = 0;
    for (int i = 0; i < WH; i++) frm[i] = DW'($urandom_range(0, 63));
    build_golden();
    clear_mon();
    send_frame(1'b1, 3 * W);
    do_reset();
    n_checks += 2;
    if (valid_out !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL mreset_state got=%b%b want=01", valid_out, in_ready);
    end
    clear_mon();
    send_frame(1'b0, WH);
    drain(WH);
    if (out_q.size() != WH) begin
      n_fail++; $display("FAIL mreset_count got=%0d want=%0d", out_q.size(), WH);
    end
    n_checks++;
    for (int i = 0; i < out_q.size() && i < WH; i++)
      if (out_q[i] !== exp_v[i]) bad++;
    if (bad != 0) begin
      n_fail++; $display("FAIL mreset_values bad=%0d want=0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_constant();
    test_salt();
    test_border();
    test_random(1'b0);
    test_random(1'b1);
    test_back_to_back();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
